// File: rtl/mdio_mmd_responder.sv
// mdio_mmd_responder
//   Clause 45 MDIO manageable-device responder. It oversamples mdc/mdio on
//   clk156 and decodes ADDRESS, WRITE, READ and POST-READ-INCREMENT frames
//   addressed to prtad. Decoded frames are turned into single-cycle register
//   strobes, and read data is driven back onto the bus.
//
// Ports
//   clk156      sole clock
//   aresetn     asynchronous active-low reset
//   prtad[4:0]  port address of this device (quasi-static)
//   mdc         management clock from the master (asynchronous)
//   mdio_in     serial data from the master
//   mdio_out    serial data to the master
//   mdio_tri    1 = line released, 0 = drive mdio_out
//   reg_devad   DEVAD of the current access
//   reg_addr    internal address register
//   reg_wr      one-cycle write strobe, reg_wrdata valid with it
//   reg_rd      one-cycle read strobe
//   reg_rddata  read data, sampled C_RD_LAT cycles after reg_rd
module mdio_mmd_responder #(
  parameter int C_RD_LAT = 2
) (
  input  logic        clk156,
  input  logic        aresetn,
  input  logic [4:0]  prtad,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_tri,
  output logic [4:0]  reg_devad,
  output logic [15:0] reg_addr,
  output logic        reg_wr,
  output logic [15:0] reg_wrdata,
  output logic        reg_rd,
  input  logic [15:0] reg_rddata
);

  typedef enum logic [2:0] {
    S_PRE, S_ST, S_OP, S_PRT, S_DEV, S_TA, S_DATA
  } state_t;

  localparam logic [1:0] OP_ADDR = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_PRI  = 2'b10;

  // Synchronizer stages: p0/p1 form the 2-FF synchronizer, p2 is the edge detector history.
  logic mdc_p0, mdc_p1, mdc_p2;
  logic mdio_p0, mdio_p1;
  logic bit_ce;

  state_t      state;
  logic [4:0]  bit_cnt;
  logic [5:0]  pre_cnt;
  logic [1:0]  op;
  logic [4:0]  field_sr;
  logic [15:0] rx_sr;
  logic [15:0] tx_sr;
  logic [3:0]  lat_cnt;
  logic        inc_pend;
  logic [4:0]  field_nxt;
  logic [15:0] rx_nxt;

  // Synchronizers reset high so a released reset with mdc low never fakes a rising edge.
  always_ff @(posedge clk156 or negedge aresetn) begin
    if (!aresetn) begin
      mdc_p0  <= 1'b1;
      mdc_p1  <= 1'b1;
      mdc_p2  <= 1'b1;
      mdio_p0 <= 1'b1;
      mdio_p1 <= 1'b1;
    end else begin
      mdc_p0  <= mdc;
      mdc_p1  <= mdc_p0;
      mdc_p2  <= mdc_p1;
      mdio_p0 <= mdio_in;
      mdio_p1 <= mdio_p0;
    end
  end

  assign bit_ce    = mdc_p1 & ~mdc_p2;
  assign field_nxt = {field_sr[3:0], mdio_p1};
  assign rx_nxt    = {rx_sr[14:0], mdio_p1};

  always_ff @(posedge clk156 or negedge aresetn) begin
    if (!aresetn) begin
      state      <= S_PRE;
      bit_cnt    <= '0;
      pre_cnt    <= '0;
      op         <= '0;
      field_sr   <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      lat_cnt    <= '0;
      inc_pend   <= 1'b0;
      mdio_out   <= 1'b1;
      mdio_tri   <= 1'b1;
      reg_devad  <= '0;
      reg_addr   <= '0;
      reg_wr     <= 1'b0;
      reg_wrdata <= '0;
      reg_rd     <= 1'b0;
    end else begin
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;

      // Post-read-increment lands the cycle after the line is released.
      if (inc_pend) begin
        reg_addr <= reg_addr + 16'd1;
        inc_pend <= 1'b0;
      end

      // Read latency counter: the register file answers C_RD_LAT cycles after reg_rd.
      if (reg_rd)
        lat_cnt <= 4'(C_RD_LAT);
      else if (lat_cnt != 4'd0)
        lat_cnt <= lat_cnt - 4'd1;
      if (lat_cnt == 4'd1)
        tx_sr <= reg_rddata;

      if (bit_ce) begin
        case (state)
          S_PRE: begin
            if (mdio_p1) begin
              if (pre_cnt != 6'd32) pre_cnt <= pre_cnt + 6'd1;
            end else begin
              // A 0 after a full preamble is the first ST bit.
              if (pre_cnt == 6'd32) state <= S_ST;
              pre_cnt <= '0;
            end
          end
          S_ST: begin
            // ST = 01 is a Clause 22 frame: not ours.
            if (mdio_p1) state <= S_PRE;
            else begin
              state   <= S_OP;
              bit_cnt <= '0;
            end
          end
          S_OP: begin
            op <= {op[0], mdio_p1};
            if (bit_cnt == 5'd1) begin
              state   <= S_PRT;
              bit_cnt <= '0;
            end else bit_cnt <= bit_cnt + 5'd1;
          end
          S_PRT: begin
            field_sr <= field_nxt;
            if (bit_cnt == 5'd4) begin
              bit_cnt <= '0;
              state   <= (field_nxt == prtad) ? S_DEV : S_PRE;
            end else bit_cnt <= bit_cnt + 5'd1;
          end
          S_DEV: begin
            field_sr <= field_nxt;
            if (bit_cnt == 5'd4) begin
              reg_devad <= field_nxt;
              reg_rd    <= op[1];
              bit_cnt   <= '0;
              state     <= S_TA;
            end else bit_cnt <= bit_cnt + 5'd1;
          end
          S_TA: begin
            if (bit_cnt == 5'd0) begin
              // Drive the second TA bit low for reads.
              if (op[1]) begin
                mdio_tri <= 1'b0;
                mdio_out <= 1'b0;
              end
              bit_cnt <= 5'd1;
            end else begin
              if (op[1]) begin
                mdio_out <= tx_sr[15];
                tx_sr    <= {tx_sr[14:0], 1'b0};
              end
              bit_cnt <= '0;
              state   <= S_DATA;
            end
          end
          S_DATA: begin
            rx_sr <= rx_nxt;
            if (op[1]) begin
              if (bit_cnt == 5'd15) begin
                // D0 has been on the line for a full mdc period: release.
                mdio_tri <= 1'b1;
                mdio_out <= 1'b1;
                inc_pend <= (op == OP_PRI);
                state    <= S_PRE;
              end else begin
                mdio_out <= tx_sr[15];
                tx_sr    <= {tx_sr[14:0], 1'b0};
              end
            end else if (bit_cnt == 5'd15) begin
              if (op == OP_ADDR) reg_addr <= rx_nxt;
              if (op == OP_WR) begin
                reg_wr     <= 1'b1;
                reg_wrdata <= rx_nxt;
              end
              state <= S_PRE;
            end
            bit_cnt <= bit_cnt + 5'd1;
          end
          default: state <= S_PRE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_mmd_responder.sv
// tb_mdio_mmd_responder
//   Directed bench for mdio_mmd_responder: a table of whole MDIO frames with
//   hand-computed strobe counts, address results and read words, followed by
//   hand-written Clause 22, short-preamble and mid-frame reset sequences.
module tb_mdio_mmd_responder;

  logic        clk156 = 1'b0;
  logic        aresetn = 1'b0;
  logic [4:0]  prtad = 5'h03;
  logic        mdc = 1'b0;
  logic        mdio_in = 1'b1;
  logic        mdio_out, mdio_tri;
  logic [4:0]  reg_devad;
  logic [15:0] reg_addr;
  logic        reg_wr;
  logic [15:0] reg_wrdata;
  logic        reg_rd;
  logic [15:0] reg_rddata = 16'h0000;

  int total = 0;
  int bad   = 0;

  // Strobe monitors (written only by this always block).
  int          wr_cnt = 0, rd_cnt = 0, both_cnt = 0, tri_low_cnt = 0;
  logic [15:0] last_wrdata = '0, last_rd_addr = '0;
  logic [4:0]  last_wr_devad = '0, last_rd_devad = '0;

  mdio_mmd_responder #(.C_RD_LAT(2)) dut (
    .clk156(clk156), .aresetn(aresetn), .prtad(prtad), .mdc(mdc),
    .mdio_in(mdio_in), .mdio_out(mdio_out), .mdio_tri(mdio_tri),
    .reg_devad(reg_devad), .reg_addr(reg_addr), .reg_wr(reg_wr),
    .reg_wrdata(reg_wrdata), .reg_rd(reg_rd), .reg_rddata(reg_rddata)
  );

  always #5 clk156 = ~clk156;

  always @(negedge clk156) begin
    if (reg_wr) begin
      wr_cnt        <= wr_cnt + 1;
      last_wrdata   <= reg_wrdata;
      last_wr_devad <= reg_devad;
    end
    if (reg_rd) begin
      rd_cnt        <= rd_cnt + 1;
      last_rd_addr  <= reg_addr;
      last_rd_devad <= reg_devad;
    end
    if (reg_wr && reg_rd) both_cnt <= both_cnt + 1;
    if (!mdio_tri) tri_low_cnt <= tri_low_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One mdc period: data set while mdc is low, line observed just before the rising edge.
  task automatic send_bit(input logic b, output logic line, output logic tri_v);
    @(negedge clk156);
    mdc     = 1'b0;
    mdio_in = b;
    repeat (9) @(negedge clk156);
    tri_v = mdio_tri;
    line  = mdio_tri ? 1'b1 : mdio_out;
    mdc   = 1'b1;
    repeat (10) @(negedge clk156);
  endtask

  task automatic pulse_reset();
    @(negedge clk156);
    #2 aresetn = 1'b0;
    #1;
    chk("rst_mid_tri", 32'(mdio_tri), 32'd1);
    chk("rst_mid_out", 32'(mdio_out), 32'd1);
    chk("rst_mid_addr", 32'(reg_addr), 32'd0);
    chk("rst_mid_devad", 32'(reg_devad), 32'd0);
    repeat (2) @(negedge clk156);
    aresetn = 1'b1;
  endtask

  task automatic run_frame(input int npre, input logic [1:0] st, input logic [1:0] op,
                           input logic [4:0] prt, input logic [4:0] dev,
                           input logic [15:0] data, input int rst_bit,
                           output logic [15:0] word, output logic ta0_tri,
                           output logic ta1_tri, output logic ta1_line,
                           output logic end_tri);
    logic l, t;
    logic rdop;
    rdop = op[1];
    for (int i = 0; i < npre; i++) send_bit(1'b1, l, t);
    send_bit(st[1], l, t);
    send_bit(st[0], l, t);
    send_bit(op[1], l, t);
    send_bit(op[0], l, t);
    for (int i = 4; i >= 0; i--) send_bit(prt[i], l, t);
    for (int i = 4; i >= 0; i--) send_bit(dev[i], l, t);
    send_bit(1'b1, l, ta0_tri);
    send_bit(rdop ? 1'b1 : 1'b0, ta1_line, ta1_tri);
    word = '0;
    for (int i = 15; i >= 0; i--) begin
      if (15 - i == rst_bit) pulse_reset();
      send_bit(rdop ? 1'b1 : data[i], l, t);
      word[i] = l;
    end
    end_tri = mdio_tri;
    repeat (6) @(negedge clk156);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  prt;
    logic [4:0]  dev;
    logic [15:0] data;
    logic [15:0] rdd;
    int          n_wr;
    int          n_rd;
    logic [15:0] addr_after;
    logic [15:0] rd_addr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [15:0] word;
    logic ta0_tri, ta1_tri, ta1_line, end_tri;
    int wr0, rd0, tl0;

    vecs[0] = '{2'b00, 5'h03, 5'h01, 16'h1234, 16'h0000, 0, 0, 16'h1234, 16'h0000};
    vecs[1] = '{2'b01, 5'h03, 5'h01, 16'hBEEF, 16'h0000, 1, 0, 16'h1234, 16'h0000};
    vecs[2] = '{2'b11, 5'h03, 5'h01, 16'h0000, 16'hA5C3, 0, 1, 16'h1234, 16'h1234};
    vecs[3] = '{2'b00, 5'h03, 5'h07, 16'hFFFF, 16'h0000, 0, 0, 16'hFFFF, 16'h0000};
    vecs[4] = '{2'b10, 5'h03, 5'h07, 16'h0000, 16'h1111, 0, 1, 16'h0000, 16'hFFFF};
    vecs[5] = '{2'b10, 5'h03, 5'h07, 16'h0000, 16'h2222, 0, 1, 16'h0001, 16'h0000};
    vecs[6] = '{2'b01, 5'h04, 5'h01, 16'h0F0F, 16'h0000, 0, 0, 16'h0001, 16'h0000};
    vecs[7] = '{2'b11, 5'h04, 5'h01, 16'h0000, 16'hFFFF, 0, 0, 16'h0001, 16'h0000};

    // Reset values
    repeat (3) @(negedge clk156);
    chk("rst_tri", 32'(mdio_tri), 32'd1);
    chk("rst_out", 32'(mdio_out), 32'd1);
    chk("rst_wr", 32'(reg_wr), 32'd0);
    chk("rst_rd", 32'(reg_rd), 32'd0);
    chk("rst_devad", 32'(reg_devad), 32'd0);
    chk("rst_addr", 32'(reg_addr), 32'd0);
    chk("rst_wrdata", 32'(reg_wrdata), 32'd0);
    aresetn = 1'b1;
    repeat (3) @(negedge clk156);

    for (int v = 0; v < 8; v++) begin
      wr0 = wr_cnt; rd0 = rd_cnt; tl0 = tri_low_cnt;
      reg_rddata = vecs[v].rdd;
      run_frame(32, 2'b00, vecs[v].op, vecs[v].prt, vecs[v].dev, vecs[v].data, -1,
                word, ta0_tri, ta1_tri, ta1_line, end_tri);
      chk($sformatf("v%0d_wr_count", v), 32'(wr_cnt - wr0), 32'(vecs[v].n_wr));
      chk($sformatf("v%0d_rd_count", v), 32'(rd_cnt - rd0), 32'(vecs[v].n_rd));
      chk($sformatf("v%0d_addr", v), 32'(reg_addr), 32'(vecs[v].addr_after));
      chk($sformatf("v%0d_end_tri", v), 32'(end_tri), 32'd1);
      if (vecs[v].n_wr != 0) begin
        chk($sformatf("v%0d_wrdata", v), 32'(last_wrdata), 32'(vecs[v].data));
        chk($sformatf("v%0d_wr_devad", v), 32'(last_wr_devad), 32'(vecs[v].dev));
      end
      if (vecs[v].n_rd != 0) begin
        chk($sformatf("v%0d_rd_word", v), 32'(word), 32'(vecs[v].rdd));
        chk($sformatf("v%0d_rd_addr", v), 32'(last_rd_addr), 32'(vecs[v].rd_addr));
        chk($sformatf("v%0d_rd_devad", v), 32'(last_rd_devad), 32'(vecs[v].dev));
        chk($sformatf("v%0d_ta0_tri", v), 32'(ta0_tri), 32'd1);
        chk($sformatf("v%0d_ta1_tri", v), 32'(ta1_tri), 32'd0);
        chk($sformatf("v%0d_ta1_line", v), 32'(ta1_line), 32'd0);
      end else begin
        chk($sformatf("v%0d_tri_never_low", v), 32'(tri_low_cnt - tl0), 32'd0);
      end
      if (vecs[v].prt == prtad)
        chk($sformatf("v%0d_devad", v), 32'(reg_devad), 32'(vecs[v].dev));
    end
    chk("never_wr_and_rd", 32'(both_cnt), 32'd0);

    // Clause 22 start (ST = 01) with our port address: ignored.
    wr0 = wr_cnt; rd0 = rd_cnt; tl0 = tri_low_cnt;
    run_frame(32, 2'b01, 2'b01, 5'h03, 5'h02, 16'h0000, -1,
              word, ta0_tri, ta1_tri, ta1_line, end_tri);
    chk("c22_wr_count", 32'(wr_cnt - wr0), 32'd0);
    chk("c22_rd_count", 32'(rd_cnt - rd0), 32'd0);
    chk("c22_tri_low", 32'(tri_low_cnt - tl0), 32'd0);

    // 31-bit preamble: ignored.
    wr0 = wr_cnt;
    run_frame(31, 2'b00, 2'b01, 5'h03, 5'h02, 16'h0055, -1,
              word, ta0_tri, ta1_tri, ta1_line, end_tri);
    chk("short_pre_wr_count", 32'(wr_cnt - wr0), 32'd0);

    // Full preamble WRITE 0x0055: exactly one strobe.
    wr0 = wr_cnt;
    run_frame(32, 2'b00, 2'b01, 5'h03, 5'h02, 16'h0055, -1,
              word, ta0_tri, ta1_tri, ta1_line, end_tri);
    chk("full_pre_wr_count", 32'(wr_cnt - wr0), 32'd1);
    chk("full_pre_wrdata", 32'(last_wrdata), 32'h0055);
    chk("full_pre_devad", 32'(last_wr_devad), 32'd2);

    // READ aborted by reset during data bit 8: line released, no further read.
    wr0 = wr_cnt; rd0 = rd_cnt;
    reg_rddata = 16'h1234;
    run_frame(32, 2'b00, 2'b11, 5'h03, 5'h05, 16'h0000, 8,
              word, ta0_tri, ta1_tri, ta1_line, end_tri);
    chk("abort_rd_count", 32'(rd_cnt - rd0), 32'd1);
    chk("abort_end_tri", 32'(end_tri), 32'd1);
    chk("abort_word_high_byte", 32'(word[15:8]), 32'h12);
    chk("abort_word_low_released", 32'(word[7:0]), 32'hFF);

    // Following full READ after reset: address register is back at 0.
    rd0 = rd_cnt;
    reg_rddata = 16'h5AA5;
    run_frame(32, 2'b00, 2'b11, 5'h03, 5'h05, 16'h0000, -1,
              word, ta0_tri, ta1_tri, ta1_line, end_tri);
    chk("post_rst_rd_count", 32'(rd_cnt - rd0), 32'd1);
    chk("post_rst_rd_word", 32'(word), 32'h5AA5);
    chk("post_rst_rd_addr", 32'(last_rd_addr), 32'h0000);
    chk("post_rst_ta1_line", 32'(ta1_line), 32'd0);
    chk("post_rst_end_tri", 32'(end_tri), 32'd1);
    chk("final_never_wr_and_rd", 32'(both_cnt), 32'd0);
    chk("final_wr_total", 32'(wr_cnt - wr0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
